// File: rtl/btn_event_arbiter.sv
// btn_event_arbiter: turns debounced active-low button levels into ordered
// action requests over valid/ready. Long-press on reset/test: BTN_LONGPRESS_EN.
module btn_event_arbiter #(
    parameter int HOLD_CYCLES     = 150000000,
    parameter int COOLDOWN_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_salud_n,
    input  logic       btn_hambre_n,
    input  logic       btn_reset_n,
    input  logic       btn_test_n,
    output logic       act_valid,
    output logic [1:0] act_code,
    input  logic       act_ready,
    output logic       test_mode,
    output logic       busy,
    output logic [7:0] drop_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        COOLDOWN
    } state_t;

    localparam int CD_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;

    localparam logic [1:0] CODE_RESET = 2'd2;
    localparam logic [1:0] CODE_TEST  = 2'd3;

    if (HOLD_CYCLES < 1) begin : g_hold_chk
        $error("HOLD_CYCLES must be at least 1");
    end

    // Source order in every 4-bit vector: {test, reset, hambre, salud}
    logic [3:0] btn_n;
    logic [3:0] req;

    assign btn_n = {btn_test_n, btn_reset_n, btn_hambre_n, btn_salud_n};

`ifdef BTN_LONGPRESS_EN
    localparam int NP     = 2;
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

    logic [HOLD_W-1:0] hold_rst_q, hold_rst_d;
    logic [HOLD_W-1:0] hold_tst_q, hold_tst_d;
    logic              hold_rst_ev, hold_tst_ev;

    // Hold counters count low cycles and park at the threshold
    always_comb begin
        hold_rst_d = '0;
        hold_tst_d = '0;
        if (!btn_n[2]) begin
            hold_rst_d = (hold_rst_q == HOLD_MAX) ? hold_rst_q
                                                  : hold_rst_q + HOLD_W'(1);
        end
        if (!btn_n[3]) begin
            hold_tst_d = (hold_tst_q == HOLD_MAX) ? hold_tst_q
                                                  : hold_tst_q + HOLD_W'(1);
        end
    end

    // Hold counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_rst_q <= '0;
            hold_tst_q <= '0;
        end else begin
            hold_rst_q <= hold_rst_d;
            hold_tst_q <= hold_tst_d;
        end
    end

    // One event only on the cycle the threshold is first reached
    assign hold_rst_ev = (hold_rst_d == HOLD_MAX) && (hold_rst_q != HOLD_MAX);
    assign hold_tst_ev = (hold_tst_d == HOLD_MAX) && (hold_tst_q != HOLD_MAX);
`else
    localparam int NP = 4;
`endif

    logic [NP-1:0] prev_q, prev_d;
    logic [NP-1:0] press;

    assign prev_d = btn_n[NP-1:0];
    assign press  = prev_q & ~btn_n[NP-1:0];

`ifdef BTN_LONGPRESS_EN
    assign req = {hold_tst_ev, hold_rst_ev, press};
`else
    assign req = press;
`endif

    state_t          state_q, state_d;
    logic [3:0]      pend_q, pend_d;
    logic [1:0]      code_q, code_d;
    logic            tm_q, tm_d;
    logic [7:0]      drop_q, drop_d;
    logic [CD_W-1:0] cd_q, cd_d;
    logic [3:0]      drop;
    logic [3:0]      code_oh;
    logic [1:0]      prio_code;

    assign code_oh = 4'b0001 << code_q;

    // Fixed priority pick: reset > test > salud > hambre
    always_comb begin
        prio_code = 2'd1;
        if (pend_q[2]) begin
            prio_code = CODE_RESET;
        end else if (pend_q[3]) begin
            prio_code = CODE_TEST;
        end else if (pend_q[0]) begin
            prio_code = 2'd0;
        end
    end

    // Pending capture, drop detection and offer/cooldown sequencing
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        tm_d    = tm_q;
        cd_d    = '0;
        pend_d  = pend_q | req;
        drop    = req & pend_q;
        unique case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    code_d  = prio_code;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (act_ready) begin
                    // Same-source event on the accept edge re-arms, no drop
                    drop   = req & pend_q & ~code_oh;
                    pend_d = (pend_q & ~code_oh) | req;
                    if (code_q == CODE_TEST) begin
                        tm_d = ~tm_q;
                    end
                    if (code_q == CODE_RESET) begin
                        pend_d  = '0;
                        drop    = '0;
                        tm_d    = 1'b0;
                        state_d = IDLE;
                    end else if (COOLDOWN_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = COOLDOWN;
                    end
                end
            end
            COOLDOWN: begin
                if (int'(cd_q) >= COOLDOWN_CYCLES - 1) begin
                    state_d = IDLE;
                end else begin
                    cd_d = cd_q + CD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        drop_d = drop_q;
        if ((|drop) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    // State, pending and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prev_q  <= '1;
            pend_q  <= '0;
            code_q  <= '0;
            tm_q    <= 1'b0;
            drop_q  <= '0;
            cd_q    <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            pend_q  <= pend_d;
            code_q  <= code_d;
            tm_q    <= tm_d;
            drop_q  <= drop_d;
            cd_q    <= cd_d;
        end
    end

    assign act_valid = (state_q == OFFER);
    assign act_code  = code_q;
    assign busy      = (state_q == COOLDOWN);
    assign test_mode = tm_q;
    assign drop_cnt  = drop_q;

endmodule

// File: doc/btn_event_arbiter.md
# btn_event_arbiter

Sequences the debounced, active-low button levels of the pet console (salud, hambre, reset, test) into single, ordered action requests for the pet state machine. Each button press becomes a pending request, and a fixed-priority arbiter offers one request at a time over a valid/ready handshake. Accepted actions are followed by a cooldown window. The block sits between the button-conditioning stage and the game core, and it also owns the test-mode flag.

## Interface
- HOLD_CYCLES, 150000000, consecutive low cycles that qualify a long press on reset/test (min 1)
- COOLDOWN_CYCLES, 50000000, idle cycles enforced after each accepted non-reset action (0 = none)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- btn_salud_n  in  1  debounced salud button, 0 = pressed, synchronous to clk
- btn_hambre_n  in  1  debounced hambre button, 0 = pressed
- btn_reset_n  in  1  debounced reset button, 0 = pressed
- btn_test_n  in  1  debounced test button, 0 = pressed
- act_valid  out  1  action offered to the core
- act_code  out  2  0 = salud, 1 = hambre, 2 = reset, 3 = test; stable while act_valid
- act_ready  in  1  core accepts the action
- test_mode  out  1  test-mode flag
- busy  out  1  high during cooldown
- drop_cnt  out  8  saturating count of dropped presses

## Operation
- Reset values: act_valid 0, act_code 0, test_mode 0, busy 0, drop_cnt 0, all pending bits 0, hold counters 0, FSM IDLE. The previous-sample registers reset to 1.
- **Press event:** the input is sampled 0 while its previous sample was 1.
- **Request event for salud/hambre:** the press event itself.
- **Request event for reset/test:** see Configuration.
- **Pending bits:** one per source, set at the edge where its request event is seen.
  - If a request event arrives while that source is already pending, the event is dropped.
  - drop_cnt increments by 1 in any cycle with at least one drop, saturating at 255.
- **FSM states:**
  - IDLE: if any bit is pending, latch the highest-priority code into act_code and go to OFFER. Priority is reset > test > salud > hambre.
  - OFFER: act_valid=1 and act_code is held. No preemption by newer or higher-priority requests. On act_valid&act_ready:
    - clear the consumed pending bit;
    - if the code is test, toggle test_mode;
    - if the code is reset, clear all pending bits and test_mode and go to IDLE;
    - otherwise go to COOLDOWN, or to IDLE when COOLDOWN_CYCLES=0.
  - COOLDOWN: busy=1. The counter runs COOLDOWN_CYCLES cycles, then the FSM goes to IDLE. Request events are still captured as pending during cooldown.
- **Simultaneous events:**
  - A request event for the same source on the accept edge sets pending again (set wins) and is not counted as a drop.
  - A request event that coincides with an accepted reset action is lost and is not counted as a drop.
- **Async reset mid-OFFER:** act_valid drops immediately and no action is reported.

## Timing
- Input first sampled low at edge k → pending visible after edge k → act_valid high after edge k+1 (2-cycle latency from IDLE).
- act_valid falls after the accepting edge.
- Non-reset action: busy is high for exactly COOLDOWN_CYCLES cycles. Next act_valid rises no earlier than 1 IDLE cycle after busy falls.
- Reset action: next offer can follow after one IDLE cycle.
- test_mode and pending clears update at the accepting edge.

## Configuration
- BTN_LONGPRESS_EN defined:
  - reset and test each have a hold counter that increments while the input is low and clears when it is high;
  - a request event fires once, at the cycle the counter reaches HOLD_CYCLES;
  - continued holding produces no further events.
- BTN_LONGPRESS_EN undefined: reset and test use press events like salud/hambre. HOLD_CYCLES is ignored and the hold counters are not built.

## Test plan
Parameters for all scenarios: HOLD_CYCLES=4, COOLDOWN_CYCLES=3, BTN_LONGPRESS_EN defined, act_ready held 1 unless stated.

- **Salud single press:** btn_salud_n low for 2 cycles → act_valid for 1 cycle with act_code=0, 2 cycles after the first low sample. busy is then high for 3 cycles. drop_cnt stays 0.
- **Simultaneous press:** btn_salud_n and btn_hambre_n fall on the same edge → code 0 is offered first, then code 1 after cooldown plus one IDLE cycle.
- **Backpressure and drop:** act_ready=0, press hambre, release, press again → act_code=1 held steady, drop_cnt=1. Raising act_ready yields exactly one accept.
- **Test long press:** btn_test_n low for 3 cycles, then release → no action. Low for 6 cycles → exactly one code 3 offer, and test_mode goes 0→1 at accept. Repeating the long press returns test_mode to 0.
- **Reset priority:** salud pending in COOLDOWN, then reset held 4 cycles → after cooldown, code 2 is offered before salud. At accept, salud pending and test_mode clear, and no salud offer follows.
- **Async reset mid-OFFER:** rst_n low while act_valid=1 → act_valid=0, drop_cnt=0 and test_mode=0 immediately. After release, no offer appears until a new press.
